nms_stream: RTL and testbench

NMS_STREAM -- requirements
Module: nms_stream

---
 rtl/nms_stream_pkg.sv | 20 ++
 rtl/nms_line_buffer.sv | 24 ++
 rtl/nms_stream.sv | 184 ++++++++++++++++++
 tb/tb_nms_stream.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nms_stream_pkg.sv
// Shared types for the streaming non-maximum-suppression block: direction
// encoding, controller states and the default magnitude width.
package nms_stream_pkg;

    localparam int MAG_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        DIR_0   = 2'b00,
        DIR_90  = 2'b01,
        DIR_45  = 2'b10,
        DIR_135 = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_FILL  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

endpackage

// File: rtl/nms_line_buffer.sv
// One line of magnitude history: combinational read and synchronous write at
// the same column address. Contents are never reset.
module nms_line_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/nms_stream.sv
// Streaming 3x3 non-maximum suppression over a raster of gradient magnitudes
// with quantized directions; one output per input, border pixels forced to 0.
//
// state    | meaning
// ST_FILL  | accept pixels, no output until row 1 column 0 is accepted
// ST_RUN   | one output per accepted pixel
// ST_FLUSH | input stalled, emit the trailing IMG_W+1 outputs, then refill
module nms_stream
    import nms_stream_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int MAG_W = MAG_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [MAG_W-1:0] i_mag,
    input  logic [1:0]       i_dir,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [MAG_W-1:0] o_mag,
    output logic             o_eof
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 2);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LEN = FW'(IMG_W + 1);

    state_e           state_q;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    ocol_q;
    logic [RW-1:0]    orow_q;
    logic [FW-1:0]    flush_q;
    logic             live_q;
    logic             o_valid_q;
    logic             o_eof_q;
    logic [MAG_W-1:0] o_mag_q;

    logic             slot_free;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_out;

    logic [MAG_W-1:0] lb0_rd;
    logic [MAG_W-1:0] lb1_rd;
    logic [1:0]       dir_mem_q [IMG_W];

    // wa_q is column c-2 and wb_q column c-1 (index 0 = top row) relative to the pixel being accepted.
    logic [MAG_W-1:0] wa_q [3];
    logic [MAG_W-1:0] wb_q [3];
    dir_e             dcen_q;

    logic [MAG_W-1:0] nb_a;
    logic [MAG_W-1:0] nb_b;
    logic [MAG_W-1:0] center;
    logic             border;
    logic [MAG_W-1:0] mag_d;
    logic             eof_d;

    assign slot_free = !o_valid_q || i_ready;
    assign o_ready   = live_q && ((state_q == ST_FILL) || (state_q == ST_RUN && slot_free));
    assign in_xfer   = i_valid && o_ready;
    assign out_xfer  = o_valid_q && i_ready;
    assign load_out  = (state_q == ST_RUN && in_xfer) ||
                       (state_q == ST_FLUSH && slot_free && flush_q != '0);

    nms_line_buffer #(.DEPTH(IMG_W), .WIDTH(MAG_W)) u_lb0 (
        .i_clk   (i_clk),
        .i_we    (in_xfer),
        .i_addr  (col_q),
        .i_wdata (i_mag),
        .o_rdata (lb0_rd)
    );

    nms_line_buffer #(.DEPTH(IMG_W), .WIDTH(MAG_W)) u_lb1 (
        .i_clk   (i_clk),
        .i_we    (in_xfer),
        .i_addr  (col_q),
        .i_wdata (lb0_rd),
        .o_rdata (lb1_rd)
    );

    always_ff @(posedge i_clk) begin
        if (in_xfer) begin
            dir_mem_q[col_q] <= i_dir;
            wa_q             <= wb_q;
            wb_q[0]          <= lb1_rd;
            wb_q[1]          <= lb0_rd;
            wb_q[2]          <= i_mag;
            dcen_q           <= dir_e'(dir_mem_q[col_q]);
        end
    end

    // Center is wb_q[1]; neighbors come from the window plus the column arriving now.
    always_comb begin
        nb_a = '0;
        nb_b = '0;
        case (dcen_q)
            DIR_0:   begin nb_a = wa_q[1]; nb_b = lb0_rd;  end
            DIR_90:  begin nb_a = wb_q[0]; nb_b = wb_q[2]; end
            DIR_45:  begin nb_a = lb1_rd;  nb_b = wa_q[2]; end
            DIR_135: begin nb_a = wa_q[0]; nb_b = i_mag;   end
            default: begin nb_a = '0;      nb_b = '0;      end
        endcase
    end

    assign center = wb_q[1];
    assign border = (ocol_q == '0) || (ocol_q == COL_LAST) ||
                    (orow_q == '0) || (orow_q == ROW_LAST);
    assign mag_d  = (state_q == ST_RUN && !border && center >= nb_a && center >= nb_b)
                    ? center : '0;
    assign eof_d  = (ocol_q == COL_LAST) && (orow_q == ROW_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_FILL;
            col_q     <= '0;
            row_q     <= '0;
            ocol_q    <= '0;
            orow_q    <= '0;
            flush_q   <= '0;
            live_q    <= 1'b0;
            o_valid_q <= 1'b0;
            o_mag_q   <= '0;
            o_eof_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;

            if (in_xfer) begin
                col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                if (col_q == COL_LAST) begin
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end
            end

            if (load_out) begin
                o_valid_q <= 1'b1;
                o_mag_q   <= mag_d;
                o_eof_q   <= eof_d;
                ocol_q    <= (ocol_q == COL_LAST) ? '0 : ocol_q + 1'b1;
                if (ocol_q == COL_LAST) begin
                    orow_q <= (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
                end
                if (state_q == ST_FLUSH) begin
                    flush_q <= flush_q - 1'b1;
                end
            end else if (out_xfer) begin
                o_valid_q <= 1'b0;
                o_eof_q   <= 1'b0;
            end

            case (state_q)
                ST_FILL: begin
                    if (in_xfer && row_q == RW'(1) && col_q == '0) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_xfer && row_q == ROW_LAST && col_q == COL_LAST) begin
                        state_q <= ST_FLUSH;
                        flush_q <= FLUSH_LEN;
                    end
                end
                ST_FLUSH: begin
                    if (out_xfer && o_eof_q) begin
                        state_q <= ST_FILL;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign o_valid = o_valid_q;
    assign o_mag   = o_mag_q;
    assign o_eof   = o_eof_q;

endmodule

// File: tb/tb_nms_stream.sv
// Scoreboard bench for nms_stream: a 2D reference model queues expected outputs
// per frame, and an independent monitor pops and compares on every output transfer.
module tb_nms_stream;

    localparam int W = 16;
    localparam int H = 16;
    localparam int N = W * H;

    typedef struct packed {
        logic [7:0] mag;
        logic       eof;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] i_mag = '0;
    logic [1:0] i_dir = '0;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic [7:0] o_mag;
    logic       o_eof;

    nms_stream #(.IMG_W(W), .IMG_H(H), .MAG_W(8)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_mag   (i_mag),
        .i_dir   (i_dir),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_mag   (o_mag),
        .o_eof   (o_eof)
    );

    always #5 i_clk = ~i_clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         out_cnt = 0;
    bit         stall_en = 1'b0;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] fm [N];
    logic [1:0] fd [N];
    logic [7:0] got_mag [1024];
    bit         hold_pend = 1'b0;
    logic [7:0] hold_mag;
    logic       hold_eof;

    // i_ready pattern, driven at the falling edge
    initial begin
        forever begin
            @(negedge i_clk);
            i_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: sample mid-cycle, after i_ready has settled.
    always @(negedge i_clk) begin
        #2;
        if (!i_rst && o_valid) begin
            if (hold_pend) begin
                n_cmp++;
                if (o_mag !== hold_mag || o_eof !== hold_eof) begin
                    n_bad++;
                    $display("FAIL stall_hold: got mag=%0d eof=%0b, want mag=%0d eof=%0b",
                             o_mag, o_eof, hold_mag, hold_eof);
                end
            end
            if (i_ready) begin
                hold_pend = 1'b0;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: got mag=%0d eof=%0b, want no output", o_mag, o_eof);
                end else begin
                    mon_e = sb.pop_front();
                    if (o_mag !== mon_e.mag || o_eof !== mon_e.eof) begin
                        n_bad++;
                        $display("FAIL out[%0d]: got mag=%0d eof=%0b, want mag=%0d eof=%0b",
                                 out_cnt, o_mag, o_eof, mon_e.mag, mon_e.eof);
                    end
                end
                if (out_cnt < 1024) got_mag[out_cnt] = o_mag;
                out_cnt++;
            end else begin
                hold_pend = 1'b1;
                hold_mag  = o_mag;
                hold_eof  = o_eof;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic fill_frame(input int base, input int d);
        for (int k = 0; k < N; k++) begin
            fm[k] = 8'(base);
            fd[k] = 2'(d);
        end
    endtask

    task automatic ramp_frame();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                fm[r * W + c] = 8'(r + c);
                fd[r * W + c] = 2'((r * 3 + c) % 4);
            end
        end
    endtask

    // Neighbor pair of direction d around pixel (8,8).
    task automatic set_pair(input int d, input int val);
        int ctr;
        ctr = 8 * W + 8;
        case (d)
            0:       begin fm[ctr - 1]     = 8'(val); fm[ctr + 1]     = 8'(val); end
            1:       begin fm[ctr - W]     = 8'(val); fm[ctr + W]     = 8'(val); end
            2:       begin fm[ctr - W + 1] = 8'(val); fm[ctr + W - 1] = 8'(val); end
            default: begin fm[ctr - W - 1] = 8'(val); fm[ctr + W + 1] = 8'(val); end
        endcase
    endtask

    task automatic push_model();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                exp_t e;
                int m, a, b;
                e.mag = '0;
                e.eof = (r == H - 1) && (c == W - 1);
                if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
                    m = int'(fm[r * W + c]);
                    case (fd[r * W + c])
                        2'd0:    begin a = int'(fm[r * W + c - 1]);       b = int'(fm[r * W + c + 1]);       end
                        2'd1:    begin a = int'(fm[(r - 1) * W + c]);     b = int'(fm[(r + 1) * W + c]);     end
                        2'd2:    begin a = int'(fm[(r - 1) * W + c + 1]); b = int'(fm[(r + 1) * W + c - 1]); end
                        default: begin a = int'(fm[(r - 1) * W + c - 1]); b = int'(fm[(r + 1) * W + c + 1]); end
                    endcase
                    if (m >= a && m >= b) e.mag = 8'(m);
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_pixels(input int n);
        for (int k = 0; k < n; k++) begin
            int  budget;
            bit  acc;
            budget = 0;
            acc    = 1'b0;
            while (!acc) begin
                @(negedge i_clk);
                i_valid = 1'b1;
                i_mag   = fm[k];
                i_dir   = fd[k];
                #1;
                acc = o_ready;
                @(posedge i_clk);
                budget++;
                if (budget > 2000) begin
                    $display("FAIL send_timeout: pixel %0d not accepted within %0d cycles", k, budget);
                    $fatal(1, "input stalled");
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int n_exp);
        int b;
        b = 0;
        while ((sb.size() != 0 || o_valid) && b < 5000) begin
            @(negedge i_clk);
            #3;
            b++;
        end
        check({name, "_drain_timeout"}, (b >= 5000) ? 1 : 0, 0);
        check({name, "_count"}, out_cnt, n_exp);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge i_clk);
        #1;
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_ready", int'(o_ready), 0);
        check("rst_o_mag",   int'(o_mag),   0);
        check("rst_o_eof",   int'(o_eof),   0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        check("ready_after_rst", int'(o_ready), 1);

        // all-zero frame
        fill_frame(0, 0);
        out_cnt = 0;
        push_model();
        send_pixels(N);
        idle();
        drain("zero", N);

        // dir 0 peak at (5,5), then a stronger east neighbor
        for (int v = 0; v < 2; v++) begin
            fill_frame(10, 0);
            fm[5 * W + 5] = 8'd100;
            fm[5 * W + 4] = 8'd50;
            fm[5 * W + 6] = (v == 0) ? 8'd50 : 8'd120;
            out_cnt = 0;
            push_model();
            send_pixels(N);
            idle();
            drain("peak", N);
            check("peak_5_5", int'(got_mag[5 * W + 5]), (v == 0) ? 100 : 0);
        end

        // each direction: matching pair suppresses, other pair does not
        for (int d = 0; d < 4; d++) begin
            for (int m = 0; m < 2; m++) begin
                fill_frame(0, d);
                fm[8 * W + 8] = 8'd60;
                set_pair((m == 0) ? d : (d + 1) % 4, 70);
                out_cnt = 0;
                push_model();
                send_pixels(N);
                idle();
                drain("dir", N);
                check($sformatf("dir%0d_%s", d, (m == 0) ? "match" : "other"),
                      int'(got_mag[8 * W + 8]), (m == 0) ? 0 : 60);
            end
        end

        // ramp without and with downstream stalls
        for (int s = 0; s < 2; s++) begin
            stall_en = (s == 1);
            ramp_frame();
            out_cnt = 0;
            push_model();
            send_pixels(N);
            idle();
            drain(s == 1 ? "ramp_stall" : "ramp", N);
            check("ramp_4_6_dir45", int'(got_mag[4 * W + 6]), 10);
        end
        stall_en = 1'b0;

        // back-to-back frames
        out_cnt = 0;
        fill_frame(200, 0);
        push_model();
        send_pixels(N);
        ramp_frame();
        push_model();
        send_pixels(N);
        idle();
        drain("b2b", 2 * N);
        check("b2b_first_interior", int'(got_mag[W + 1]), 200);
        check("b2b_second_border", int'(got_mag[N + 3]), 0);

        // reset mid-frame, then a full frame
        fill_frame(0, 0);
        out_cnt = 0;
        push_model();
        send_pixels(40);
        idle();
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        #1;
        check("midrst_o_valid", int'(o_valid), 0);
        check("midrst_o_ready", int'(o_ready), 0);
        sb.delete();
        out_cnt = 0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        ramp_frame();
        for (int c = 0; c < W; c++) fm[c] = 8'd250;
        push_model();
        send_pixels(N);
        idle();
        drain("post_rst", N);
        check("post_rst_row0", int'(got_mag[5]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
